// File: rtl/id_ex_stage_if.sv
// ID/EX bundle presented to the execute stage, plus the execute stage's hold request.
// The master (decode) drives the bundle; the slave (execute) drives ex_hold.
interface id_ex_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            ex_hold;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [31:0]     ex_rs1_data;
    logic [31:0]     ex_rs2_data;
    logic [31:0]     ex_imm;
    logic [4:0]      ex_rs1;
    logic [4:0]      ex_rs2;
    logic [4:0]      ex_rd;
    logic [6:0]      ex_opcode;
    logic [2:0]      ex_funct3;
    logic [6:0]      ex_funct7;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic            ex_illegal;

    modport master (
        input  ex_hold,
        output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
        output ex_opcode, ex_funct3, ex_funct7,
        output ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal
    );

    modport slave (
        output ex_hold,
        input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
        input  ex_opcode, ex_funct3, ex_funct7,
        input  ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal
    );
endinterface

// File: rtl/id_ex_stage.sv
// RV32I decode stage and ID/EX pipeline register: operand fetch with writeback bypass,
// immediate and control generation, load-use hazard detection.
module id_ex_stage #(
    parameter int unsigned XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [31:0]     id_instr,
    input  logic [XLEN-1:0] id_pc,
    output logic [4:0]      read_index_a,
    output logic [4:0]      read_index_b,
    input  logic [31:0]     data_a,
    input  logic [31:0]     data_b,
    input  logic [4:0]      wb_index,
    input  logic [31:0]     wb_data,
    input  logic            wb_en,
    input  logic            flush,
    output logic            stall,
    id_ex_stage_if.master   ex
);

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [31:0]     rs1_data;
        logic [31:0]     rs2_data;
        logic [31:0]     imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            illegal;
    } bundle_t;

    bundle_t     dec;
    bundle_t     ex_d;
    bundle_t     ex_q;
    logic        rs1_used;
    logic        rs2_used;
    logic        load_use;
    logic [31:0] opnd_a;
    logic [31:0] opnd_b;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    // Bubbles keep the decoded data fields so the register contents stay deterministic.
    function automatic bundle_t to_bubble(input bundle_t b);
        bundle_t r;
        r           = b;
        r.valid     = 1'b0;
        r.reg_write = 1'b0;
        r.mem_read  = 1'b0;
        r.mem_write = 1'b0;
        r.illegal   = 1'b0;
        return r;
    endfunction

    assign read_index_a = id_instr[19:15];
    assign read_index_b = id_instr[24:20];

    assign imm_i = {{20{id_instr[31]}}, id_instr[31:20]};
    assign imm_s = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
    assign imm_b = {{19{id_instr[31]}}, id_instr[31], id_instr[7], id_instr[30:25],
                    id_instr[11:8], 1'b0};
    assign imm_u = {id_instr[31:12], 12'b0};
    assign imm_j = {{11{id_instr[31]}}, id_instr[31], id_instr[19:12], id_instr[20],
                    id_instr[30:21], 1'b0};

    // The register file writes on the same posedge that captures ID/EX, so forward wb_data.
    always_comb begin
        opnd_a = data_a;
        opnd_b = data_b;
        if (wb_en && (wb_index != 5'd0) && (wb_index == read_index_a)) opnd_a = wb_data;
        if (wb_en && (wb_index != 5'd0) && (wb_index == read_index_b)) opnd_b = wb_data;
        if (read_index_a == 5'd0) opnd_a = 32'd0;
        if (read_index_b == 5'd0) opnd_b = 32'd0;
    end

    always_comb begin
        dec          = '0;
        rs1_used     = 1'b0;
        rs2_used     = 1'b0;
        dec.pc       = id_pc;
        dec.rs1_data = opnd_a;
        dec.rs2_data = opnd_b;
        dec.rs1      = id_instr[19:15];
        dec.rs2      = id_instr[24:20];
        dec.rd       = id_instr[11:7];
        dec.opcode   = id_instr[6:0];
        dec.funct3   = id_instr[14:12];
        dec.funct7   = id_instr[31:25];
        unique case (id_instr[6:0])
            OpLui, OpAuipc: begin
                dec.imm       = imm_u;
                dec.reg_write = 1'b1;
            end
            OpJal: begin
                dec.imm       = imm_j;
                dec.reg_write = 1'b1;
            end
            OpJalr: begin
                dec.imm       = imm_i;
                dec.reg_write = 1'b1;
                rs1_used      = 1'b1;
            end
            OpBranch: begin
                dec.imm  = imm_b;
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            OpLoad: begin
                dec.imm       = imm_i;
                dec.reg_write = 1'b1;
                dec.mem_read  = 1'b1;
                rs1_used      = 1'b1;
            end
            OpStore: begin
                dec.imm       = imm_s;
                dec.mem_write = 1'b1;
                rs1_used      = 1'b1;
                rs2_used      = 1'b1;
            end
            OpImm: begin
                dec.imm       = imm_i;
                dec.reg_write = 1'b1;
                rs1_used      = 1'b1;
            end
            OpReg: begin
                dec.reg_write = 1'b1;
                rs1_used      = 1'b1;
                rs2_used      = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
        if (dec.rd == 5'd0) dec.reg_write = 1'b0;
        dec.valid = id_valid && (id_instr != NOP_INSTR);
        if (!dec.valid) dec = to_bubble(dec);
    end

    assign load_use = ex_q.valid && ex_q.mem_read && id_valid && (ex_q.rd != 5'd0) &&
                      ((rs1_used && (ex_q.rd == dec.rs1)) || (rs2_used && (ex_q.rd == dec.rs2)));

    assign stall = ex.ex_hold | (load_use & ~flush);

    always_comb begin
        ex_d = ex_q;
        if (flush) begin
            ex_d = to_bubble(dec);
        end else if (ex.ex_hold) begin
            ex_d = ex_q;
        end else if (load_use) begin
            ex_d = to_bubble(dec);
        end else begin
            ex_d = dec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign ex.ex_valid     = ex_q.valid;
    assign ex.ex_pc        = ex_q.pc;
    assign ex.ex_rs1_data  = ex_q.rs1_data;
    assign ex.ex_rs2_data  = ex_q.rs2_data;
    assign ex.ex_imm       = ex_q.imm;
    assign ex.ex_rs1       = ex_q.rs1;
    assign ex.ex_rs2       = ex_q.rs2;
    assign ex.ex_rd        = ex_q.rd;
    assign ex.ex_opcode    = ex_q.opcode;
    assign ex.ex_funct3    = ex_q.funct3;
    assign ex.ex_funct7    = ex_q.funct7;
    assign ex.ex_reg_write = ex_q.reg_write;
    assign ex.ex_mem_read  = ex_q.mem_read;
    assign ex.ex_mem_write = ex_q.mem_write;
    assign ex.ex_illegal   = ex_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized scoreboard bench for id_ex_stage: instructions are built by an encoder from
// (class, fields, immediate), so expected immediates are the chosen values themselves.
module tb_id_ex_stage;

    localparam logic [31:0] Nop = 32'h0000_0013;

    typedef enum int {CLui, CAuipc, CJal, CJalr, CBranch, CLoad, CStore, COpImm, COp, CIll} cls_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [6:0]  opcode;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        ill;
    } exp_t;

    typedef struct {
        exp_t       e;
        logic       stall;
        logic [4:0] ra;
        logic [4:0] rb;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [31:0] id_instr = Nop;
    logic [31:0] id_pc = '0;
    logic [4:0]  read_index_a;
    logic [4:0]  read_index_b;
    logic [31:0] data_a = '0;
    logic [31:0] data_b = '0;
    logic [4:0]  wb_index = '0;
    logic [31:0] wb_data = '0;
    logic        wb_en = 1'b0;
    logic        flush = 1'b0;
    logic        stall;

    id_ex_stage_if #(.XLEN(32)) exif ();

    id_ex_stage #(.XLEN(32), .NOP_INSTR(Nop)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_instr     (id_instr),
        .id_pc        (id_pc),
        .read_index_a (read_index_a),
        .read_index_b (read_index_b),
        .data_a       (data_a),
        .data_b       (data_b),
        .wb_index     (wb_index),
        .wb_data      (wb_data),
        .wb_en        (wb_en),
        .flush        (flush),
        .stall        (stall),
        .ex           (exif)
    );

    always #5 clk = ~clk;

    int    n_vec = 0;
    int    n_err = 0;
    item_t q[$];
    exp_t  m = '0;

    cls_t        cur_cls = COpImm;
    logic [31:0] cur_word = Nop;
    logic [31:0] cur_imm = '0;
    logic [31:0] cur_pc = 32'h0000_1000;
    logic        last_stall = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] op_of(input cls_t c);
        case (c)
            CLui:    return 7'b0110111;
            CAuipc:  return 7'b0010111;
            CJal:    return 7'b1101111;
            CJalr:   return 7'b1100111;
            CBranch: return 7'b1100011;
            CLoad:   return 7'b0000011;
            CStore:  return 7'b0100011;
            COpImm:  return 7'b0010011;
            COp:     return 7'b0110011;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic bit is_known(input logic [6:0] op);
        for (int k = 0; k < 9; k++) if (op_of(cls_t'(k)) == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] encode(input cls_t c, input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [4:0] rs2, input logic [2:0] f3,
                                           input logic [6:0] f7, input logic [31:0] imm);
        logic [6:0] op;
        op = op_of(c);
        case (c)
            CLui, CAuipc:         return {imm[31:12], rd, op};
            CJal:                 return {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            CJalr, CLoad, COpImm: return {imm[11:0], rs1, f3, rd, op};
            CStore:               return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            CBranch:              return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            default:              return {f7, rs2, rs1, f3, rd, op};
        endcase
    endfunction

    task automatic set_instr(input cls_t c, input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                             input logic [31:0] imm);
        cur_cls  = c;
        cur_word = encode(c, rd, rs1, rs2, f3, f7, imm);
        cur_imm  = (c == COp) ? 32'd0 : imm;
        cur_pc   = cur_pc + 32'd4;
    endtask

    task automatic set_illegal(input logic [6:0] op);
        logic [31:0] t;
        t        = $urandom();
        cur_cls  = CIll;
        cur_word = {t[31:7], op};
        cur_imm  = 32'd0;
        cur_pc   = cur_pc + 32'd4;
    endtask

    task automatic new_instr();
        int          r;
        int          v;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  prev_rd;
        logic [31:0] imm;
        logic [6:0]  op;
        cls_t        c;
        prev_rd = cur_word[11:7];
        r = int'($urandom_range(0, 19));
        if (r == 0) c = CLui;
        else if (r == 1) c = CAuipc;
        else if (r == 2) c = CJal;
        else if (r == 3) c = CJalr;
        else if (r <= 5) c = CBranch;
        else if (r <= 9) c = CLoad;
        else if (r <= 11) c = CStore;
        else if (r <= 14) c = COpImm;
        else if (r <= 18) c = COp;
        else c = CIll;
        if (c == CIll) begin
            do op = 7'($urandom_range(0, 127)); while (is_known(op));
            set_illegal(op);
            return;
        end
        rd  = 5'($urandom_range(0, 31));
        rs1 = ($urandom_range(0, 2) == 0) ? prev_rd : 5'($urandom_range(0, 31));
        rs2 = ($urandom_range(0, 2) == 0) ? prev_rd : 5'($urandom_range(0, 31));
        case (c)
            CBranch: v = (int'($urandom_range(0, 4095)) - 2048) * 2;
            CJal:    v = (int'($urandom_range(0, 1048575)) - 524288) * 2;
            default: v = int'($urandom_range(0, 4095)) - 2048;
        endcase
        imm = v;
        if (c == CLui || c == CAuipc) imm = $urandom() & 32'hFFFF_F000;
        set_instr(c, rd, rs1, rs2, 3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)), imm);
    endtask

    function automatic logic [31:0] opnd(input logic [4:0] idx, input logic we, input logic [4:0] wi,
                                         input logic [31:0] wd, input logic [31:0] rf);
        if (idx == 5'd0) return 32'd0;
        if (we && wi == idx) return wd;
        return rf;
    endfunction

    // One ID cycle: drive inputs on the negedge, predict stall and the next ID/EX contents.
    task automatic step(input logic fl, input logic hd, input logic iv, input logic we,
                        input logic [4:0] wi, input logic [31:0] wd, input logic [31:0] da,
                        input logic [31:0] db);
        exp_t  n;
        item_t it;
        logic  r1u;
        logic  r2u;
        logic  lu;
        logic  st;
        @(negedge clk);
        flush = fl; exif.ex_hold = hd; id_valid = iv; wb_en = we; wb_index = wi; wb_data = wd;
        data_a = da; data_b = db; id_instr = cur_word; id_pc = cur_pc;
        r1u = cur_cls inside {CJalr, CBranch, CLoad, CStore, COpImm, COp};
        r2u = cur_cls inside {CBranch, CStore, COp};
        n.rs1      = cur_word[19:15];
        n.rs2      = cur_word[24:20];
        n.rd       = cur_word[11:7];
        n.opcode   = cur_word[6:0];
        n.f3       = cur_word[14:12];
        n.f7       = cur_word[31:25];
        n.pc       = cur_pc;
        n.imm      = cur_imm;
        n.rs1_data = opnd(n.rs1, we, wi, wd, da);
        n.rs2_data = opnd(n.rs2, we, wi, wd, db);
        n.valid    = iv && (cur_word != Nop);
        n.rw  = n.valid && (n.rd != 5'd0) &&
                (cur_cls inside {CLui, CAuipc, CJal, CJalr, CLoad, COpImm, COp});
        n.mr  = n.valid && (cur_cls == CLoad);
        n.mw  = n.valid && (cur_cls == CStore);
        n.ill = n.valid && (cur_cls == CIll);
        lu = m.valid && m.mr && iv && (m.rd != 5'd0) &&
             ((r1u && m.rd == n.rs1) || (r2u && m.rd == n.rs2));
        st = hd || (lu && !fl);
        if (fl || (!hd && lu)) begin
            m = n;
            m.valid = 1'b0; m.rw = 1'b0; m.mr = 1'b0; m.mw = 1'b0; m.ill = 1'b0;
        end else if (!hd) begin
            m = n;
        end
        it.e = m; it.stall = st; it.ra = n.rs1; it.rb = n.rs2;
        q.push_back(it);
        last_stall = st;
    endtask

    task automatic go(input logic fl, input logic hd, input logic iv);
        logic [4:0] wi;
        wi = ($urandom_range(0, 3) == 0) ? cur_word[19:15] : 5'($urandom_range(0, 31));
        step(fl, hd, iv, 1'($urandom_range(0, 1)), wi, $urandom(), $urandom(), $urandom());
    endtask

    // Monitor: stall and read indices before the edge, registered bundle just after it.
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() == 0) continue;
            it = q.pop_front();
            chk("stall", 32'(stall), 32'(it.stall));
            chk("read_index_a", 32'(read_index_a), 32'(it.ra));
            chk("read_index_b", 32'(read_index_b), 32'(it.rb));
            @(posedge clk);
            #1;
            chk("ex_valid", 32'(exif.ex_valid), 32'(it.e.valid));
            chk("ex_reg_write", 32'(exif.ex_reg_write), 32'(it.e.rw));
            chk("ex_mem_read", 32'(exif.ex_mem_read), 32'(it.e.mr));
            chk("ex_mem_write", 32'(exif.ex_mem_write), 32'(it.e.mw));
            chk("ex_illegal", 32'(exif.ex_illegal), 32'(it.e.ill));
            if (it.e.valid) begin
                chk("ex_pc", exif.ex_pc, it.e.pc);
                chk("ex_rs1_data", exif.ex_rs1_data, it.e.rs1_data);
                chk("ex_rs2_data", exif.ex_rs2_data, it.e.rs2_data);
                chk("ex_imm", exif.ex_imm, it.e.imm);
                chk("ex_rs1", 32'(exif.ex_rs1), 32'(it.e.rs1));
                chk("ex_rs2", 32'(exif.ex_rs2), 32'(it.e.rs2));
                chk("ex_rd", 32'(exif.ex_rd), 32'(it.e.rd));
                chk("ex_opcode", 32'(exif.ex_opcode), 32'(it.e.opcode));
                chk("ex_funct3", 32'(exif.ex_funct3), 32'(it.e.f3));
                chk("ex_funct7", 32'(exif.ex_funct7), 32'(it.e.f7));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exif.ex_hold = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset ex_valid", 32'(exif.ex_valid), 32'd0);
        chk("reset ex_opcode", 32'(exif.ex_opcode), 32'd0);
        chk("reset ex_imm", exif.ex_imm, 32'd0);
        chk("reset ex_reg_write", 32'(exif.ex_reg_write), 32'd0);
        chk("reset stall", 32'(stall), 32'd0);
        exif.ex_hold = 1'b1;
        #1;
        chk("reset stall with hold", 32'(stall), 32'd1);
        exif.ex_hold = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Bypass and x0 protection
        set_instr(COp, 5'd3, 5'd5, 5'd0, 3'd0, 7'd0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 32'd0, 32'd0);
        set_instr(COp, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 32'd1234, 32'd77, 32'd88);
        set_instr(COpImm, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        go(1'b0, 1'b0, 1'b1);
        // Load-use: one stall, one bubble, then the add issues
        set_instr(CLoad, 5'd7, 5'd2, 5'd0, 3'b010, 7'd0, 32'd0);
        go(1'b0, 1'b0, 1'b1);
        set_instr(COp, 5'd8, 5'd7, 5'd1, 3'd0, 7'd0, 32'd0);
        go(1'b0, 1'b0, 1'b1);
        go(1'b0, 1'b0, 1'b1);
        // Flush beats hold and load-use
        set_instr(CLoad, 5'd7, 5'd2, 5'd0, 3'b010, 7'd0, 32'd0);
        go(1'b0, 1'b0, 1'b1);
        set_instr(COp, 5'd8, 5'd7, 5'd1, 3'd0, 7'd0, 32'd0);
        go(1'b1, 1'b1, 1'b1);
        set_instr(CLoad, 5'd7, 5'd2, 5'd0, 3'b010, 7'd0, 32'd0);
        go(1'b0, 1'b0, 1'b1);
        set_instr(COp, 5'd8, 5'd7, 5'd1, 3'd0, 7'd0, 32'd0);
        go(1'b1, 1'b0, 1'b1);
        // Immediates and illegal opcode
        set_instr(CBranch, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFF8);
        go(1'b0, 1'b0, 1'b1);
        set_instr(CJal, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
        go(1'b0, 1'b0, 1'b1);
        set_instr(CLui, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCD_E000);
        go(1'b0, 1'b0, 1'b1);
        set_instr(CStore, 5'd0, 5'd2, 5'd3, 3'b010, 7'd0, 32'hFFFF_FFFC);
        go(1'b0, 1'b0, 1'b1);
        go(1'b0, 1'b1, 1'b1);
        set_illegal(7'b1111111);
        go(1'b0, 1'b0, 1'b1);
        go(1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 600; i++) begin
            logic fl;
            logic hd;
            logic iv;
            if (!last_stall || flush) new_instr();
            fl = ($urandom_range(0, 9) == 0);
            hd = ($urandom_range(0, 7) == 0);
            iv = ($urandom_range(0, 9) != 0);
            go(fl, hd, iv);
        end

        // Asynchronous reset while a real instruction sits in ID/EX
        set_instr(COp, 5'd9, 5'd3, 5'd4, 3'd0, 7'd0, 32'd0);
        go(1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async reset ex_valid", 32'(exif.ex_valid), 32'd0);
        chk("async reset ex_reg_write", 32'(exif.ex_reg_write), 32'd0);
        chk("async reset ex_opcode", 32'(exif.ex_opcode), 32'd0);
        chk("async reset stall", 32'(stall), 32'd0);
        m = '0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (!last_stall || flush) new_instr();
            go(($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0), 1'b1);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
Decode stage plus ID/EX pipeline register of the pipelined RV32I core. It takes the instruction from the IF/ID register, drives the register file read indices and captures the returned operands. A same-cycle writeback bypass covers the register file's posedge write. It also generates immediates and control bits, detects load-use hazards, and presents a registered bundle to the execute stage.

Parameters:
XLEN, 32, datapath and PC width
NOP_INSTR, 32'h00000013, encoding treated as bubble (addi x0,x0,0)

Ports:
clk  in  1  clock, all state updates on posedge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  IF/ID holds a valid instruction
id_instr  in  32  instruction word
id_pc  in  XLEN  instruction PC
read_index_a  out  5  rs1 field to register file (combinational)
read_index_b  out  5  rs2 field to register file (combinational)
data_a  in  32  register file operand A
data_b  in  32  register file operand B
wb_index  in  5  writeback destination (same signals the register file sees)
wb_data  in  32  writeback data
wb_en  in  1  writeback enable
flush  in  1  branch/jump redirect from EX: kill the instruction in ID
ex_hold  in  1  downstream cannot accept: freeze ID/EX
stall  out  1  hold IF/ID and PC this cycle (combinational)
ex_valid  out  1  ID/EX contains a real instruction
ex_pc  out  XLEN  registered PC
ex_rs1_data, ex_rs2_data  out  32  registered operands
ex_imm  out  32  sign-extended immediate
ex_rs1, ex_rs2, ex_rd  out  5  register indices, for EX forwarding
ex_opcode  out  7; ex_funct3  out  3; ex_funct7  out  7  decoded fields
ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal  out  1  control bits

Behaviour:
- Reset (async, rst_n=0): every ex_* output is 0, ex_opcode is 0, ex_valid is 0. stall follows its equation with ex_valid=0, so it is 0 unless ex_hold=1. Deassertion takes effect at the next posedge.
- Decode is combinational on id_instr. read_index_a=instr[19:15] and read_index_b=instr[24:20], always, regardless of validity.
- Operand bypass: the operand takes wb_data when wb_en=1, wb_index!=0 and wb_index equals the index. Otherwise it takes data_a or data_b. Index 0 always yields 0.
- Immediate by opcode:
  - I-type (LOAD, OP-IMM, JALR)
  - S-type (STORE)
  - B-type (BRANCH)
  - U-type (LUI, AUIPC)
  - J-type (JAL)
  - All others: 0
  - All immediates are sign-extended to 32 bits. B and J immediates have bit0=0.
- Control bits:
  - reg_write: LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, and only when rd!=0.
  - mem_read: LOAD. mem_write: STORE.
  - Unknown opcode: illegal=1 and all other controls 0.
- rs1 is used for JALR, BRANCH, LOAD, STORE, OP-IMM and OP. rs2 is used for BRANCH, STORE and OP.
- load_use = ex_valid & ex_mem_read & id_valid & (ex_rd!=0) & ((rs1_used & ex_rd==rs1) | (rs2_used & ex_rd==rs2)).
- stall = ex_hold | (load_use & ~flush).
- Posedge update, in priority order:
  1. flush=1: load a bubble (ex_valid=0, all controls 0). flush overrides ex_hold.
  2. ex_hold=1: ID/EX keeps its contents.
  3. load_use=1: load a bubble. The IF/ID instruction is held via stall and re-decoded next cycle; the load's data then arrives through EX/MEM forwarding, which lives outside this block.
  4. Otherwise: capture the decoded bundle, with ex_valid=id_valid.
- Bubble rule: id_valid=0 or id_instr==NOP_INSTR loads ex_valid=0 with all controls 0. Data fields are don't-care but deterministic: they are captured as decoded.
- Latency: one cycle from ID to the ex_* outputs. Throughput is one instruction per cycle without hazards.
- A load-use stall lasts exactly one cycle, because the bubble clears ex_mem_read.

Test Plan:
- Reset mid-stream: drive rst_n=0 asynchronously while ex_valid=1 -> ex_valid and all controls drop immediately without a clock; stall=0.
- Bypass: wb_en=1, wb_index=5, wb_data=32'hDEADBEEF, register file returns 0; decode "add x3,x5,x0" -> ex_rs1_data=DEADBEEF, ex_rs2_data=0, ex_rd=3, ex_reg_write=1.
- x0 protection: wb_en=1, wb_index=0, wb_data=1234; decode "add x1,x0,x0" -> ex_rs1_data=0. "addi x0,x0,5" -> ex_reg_write=0.
- Load-use: "lw x7,0(x2)" followed by "add x8,x7,x1" -> stall=1 for one cycle and one bubble cycle (ex_valid=0); the add is issued on the next cycle with ex_rs1=7.
- Flush priority: flush=1 together with ex_hold=1 and a load-use condition -> next ex_valid=0, stall equals ex_hold (1). With flush=1 and ex_hold=0 -> stall=0.
- Immediates:
  - "beq x1,x2,-8" -> ex_imm=FFFFFFF8.
  - "jal x1,+2048" -> ex_imm=00000800.
  - "lui x4,0xABCDE" -> ex_imm=ABCDE000.
  - "sw x3,-4(x2)" -> ex_imm=FFFFFFFC and ex_mem_write=1.
  - Opcode 7'b1111111 -> ex_illegal=1.
